// File: rtl/sump3_rle_pkg.sv
// Shared constants, state encoding and width helper for the SUMP3 RLE capture engine.
package sump3_rle_pkg;

    localparam logic [1:0] RLE_CODE_CHANGE = 2'b11;
    localparam logic [1:0] RLE_CODE_ROLL   = 2'b10;
    localparam logic [1:0] RLE_CODE_TRIG   = 2'b01;
    localparam logic [1:0] RLE_CODE_NONE   = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } rle_state_e;

    // Width of one RAM entry {code, timestamp, data}.
    function automatic int rle_ram_width_f(input int code_bits, input int ts_bits, input int data_bits);
        return code_bits + ts_bits + data_bits;
    endfunction

endpackage

// File: rtl/sump3_rle_capture_engine_ram.sv
// Simple dual-port inferred RAM with registered read; read-during-write returns old data.
module sump3_rle_ram #(
    parameter int DEPTH      = 1024,
    parameter int DEPTH_BITS = 10,
    parameter int WIDTH      = 36
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [DEPTH_BITS-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic [DEPTH_BITS-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_rd_data;

    // Write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sump3_rle_capture_engine.sv
// SUMP3 RLE capture engine: writes {code, ts, data} entries on change, rollover or trigger.
// Optional build macro SUMP3_RLE_MASK_EN adds cfg_event_mask to exclude bits from change detection.
module sump3_rle_capture_engine
    import sump3_rle_pkg::*;
#(
    parameter int rle_ram_depth_len  = 1024,
    parameter int rle_ram_depth_bits = 10,
    parameter int rle_data_bits      = 20,
    parameter int rle_timestamp_bits = 14,
    parameter int rle_code_bits      = 2,
    localparam int rle_ram_width = rle_ram_width_f(rle_code_bits, rle_timestamp_bits, rle_data_bits)
) (
    input  logic                          clk_cap,
    input  logic                          reset,
    input  logic [rle_data_bits-1:0]      events,
    input  logic                          arm,
    input  logic                          trigger,
    input  logic [rle_ram_depth_bits-1:0] cfg_post_len,
`ifdef SUMP3_RLE_MASK_EN
    input  logic [rle_data_bits-1:0]      cfg_event_mask,
`endif
    input  logic [rle_ram_depth_bits-1:0] rd_addr,
    output logic [rle_ram_width-1:0]      rd_data,
    output logic [1:0]                    state,
    output logic [rle_ram_depth_bits-1:0] trig_ptr,
    output logic [rle_ram_depth_bits-1:0] wr_ptr,
    output logic                          wrapped
);

    localparam logic [rle_timestamp_bits-1:0] TS_ONE  = {{(rle_timestamp_bits-1){1'b0}}, 1'b1};
    localparam logic [rle_ram_depth_bits-1:0] PTR_ONE = {{(rle_ram_depth_bits-1){1'b0}}, 1'b1};

    rle_state_e                    r_state, w_state_nxt;
    logic [rle_timestamp_bits-1:0] r_ts, w_ts_nxt;
    logic [rle_ram_depth_bits-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [rle_ram_depth_bits-1:0] r_trig_ptr, w_trig_ptr_nxt;
    logic [rle_ram_depth_bits-1:0] r_post_cnt, w_post_cnt_nxt;
    logic                          r_wrapped, w_wrapped_nxt;
    logic                          r_first, w_first_nxt;
    logic [rle_data_bits-1:0]      r_events_d1, r_events_d2;
    logic [rle_data_bits-1:0]      w_change_bits;
    logic                          w_we;
    logic [1:0]                    w_code;
    logic [rle_ram_width-1:0]      w_wr_data;

`ifdef SUMP3_RLE_MASK_EN
    assign w_change_bits = (r_events_d1 ^ r_events_d2) & ~cfg_event_mask;
`else
    assign w_change_bits = r_events_d1 ^ r_events_d2;
`endif

    // Event pipeline: d1 is the stored sample, d2 its predecessor for change detection.
    always_ff @(posedge clk_cap) begin
        r_events_d1 <= events;
        r_events_d2 <= r_events_d1;
    end

    // Next-state, write decision and pointer update (one write per cycle at most).
    always_comb begin
        w_state_nxt    = r_state;
        w_ts_nxt       = r_ts;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_trig_ptr_nxt = r_trig_ptr;
        w_post_cnt_nxt = r_post_cnt;
        w_wrapped_nxt  = r_wrapped;
        w_first_nxt    = r_first;
        w_we           = 1'b0;
        w_code         = RLE_CODE_NONE;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    w_state_nxt   = ST_ARMED;
                    w_ts_nxt      = '0;
                    w_wr_ptr_nxt  = '0;
                    w_wrapped_nxt = 1'b0;
                    w_first_nxt   = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_ARMED, ST_POST: begin
                w_ts_nxt    = r_ts + TS_ONE;
                w_first_nxt = 1'b0;
                if ((r_state == ST_ARMED) && trigger) begin
                    w_we           = 1'b1;
                    w_code         = RLE_CODE_TRIG;
                    w_trig_ptr_nxt = r_wr_ptr;
                    // cfg_post_len is depth_bits wide, so it can never exceed depth-1.
                    w_post_cnt_nxt = cfg_post_len;
                    w_state_nxt    = (cfg_post_len == '0) ? ST_DONE : ST_POST;
                end else if (r_ts == '1) begin
                    w_we   = 1'b1;
                    w_code = RLE_CODE_ROLL;
                end else if (r_first || (w_change_bits != '0)) begin
                    w_we   = 1'b1;
                    w_code = RLE_CODE_CHANGE;
                end else begin
                    w_we = 1'b0;
                end
                if (w_we) begin
                    w_wr_ptr_nxt  = r_wr_ptr + PTR_ONE;
                    w_wrapped_nxt = r_wrapped | (r_wr_ptr == '1);
                end else begin
                    w_wr_ptr_nxt = r_wr_ptr;
                end
                if (w_we && (r_state == ST_POST)) begin
                    w_post_cnt_nxt = r_post_cnt - PTR_ONE;
                    w_state_nxt    = (r_post_cnt == PTR_ONE) ? ST_DONE : ST_POST;
                end else begin
                    w_post_cnt_nxt = w_post_cnt_nxt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture state registers with synchronous reset.
    always_ff @(posedge clk_cap) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ts       <= '0;
            r_wr_ptr   <= '0;
            r_trig_ptr <= '0;
            r_post_cnt <= '0;
            r_wrapped  <= 1'b0;
            r_first    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ts       <= w_ts_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_trig_ptr <= w_trig_ptr_nxt;
            r_post_cnt <= w_post_cnt_nxt;
            r_wrapped  <= w_wrapped_nxt;
            r_first    <= w_first_nxt;
        end
    end

    assign w_wr_data = {w_code, r_ts, r_events_d1};

    sump3_rle_ram #(
        .DEPTH      (rle_ram_depth_len),
        .DEPTH_BITS (rle_ram_depth_bits),
        .WIDTH      (rle_ram_width)
    ) u_ram (
        .i_clk     (clk_cap),
        .i_reset   (reset),
        .i_we      (w_we & ~reset),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign state    = r_state;
    assign trig_ptr = r_trig_ptr;
    assign wr_ptr   = r_wr_ptr;
    assign wrapped  = r_wrapped;

endmodule

// File: tb/tb_sump3_rle_capture_engine.sv
// Scoreboard bench for sump3_rle_capture_engine: directed scenarios plus random traffic vs a reference model.
module tb_sump3_rle_capture_engine;

    localparam int DB = 4;
    localparam int DL = 16;
    localparam int DW = 8;
    localparam int TB = 4;
    localparam int RW = 2 + TB + DW;

    logic          clk_cap = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] events = '0;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic [DB-1:0] cfg_post_len = '0;
    logic [DB-1:0] rd_addr = '0;
    logic [RW-1:0] rd_data;
    logic [1:0]    state;
    logic [DB-1:0] trig_ptr;
    logic [DB-1:0] wr_ptr;
    logic          wrapped;
    logic [DW-1:0] mask_v = '0;
`ifdef SUMP3_RLE_MASK_EN
    wire  [DW-1:0] cfg_event_mask = mask_v;
`endif

    always #5 clk_cap = ~clk_cap;

    sump3_rle_capture_engine #(
        .rle_ram_depth_len  (DL),
        .rle_ram_depth_bits (DB),
        .rle_data_bits      (DW),
        .rle_timestamp_bits (TB),
        .rle_code_bits      (2)
    ) dut (
        .clk_cap        (clk_cap),
        .reset          (reset),
        .events         (events),
        .arm            (arm),
        .trigger        (trigger),
        .cfg_post_len   (cfg_post_len),
`ifdef SUMP3_RLE_MASK_EN
        .cfg_event_mask (cfg_event_mask),
`endif
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .state          (state),
        .trig_ptr       (trig_ptr),
        .wr_ptr         (wr_ptr),
        .wrapped        (wrapped)
    );

    typedef struct {
        int            due;
        logic [1:0]    st;
        logic [DB-1:0] wp;
        logic [DB-1:0] tp;
        logic          wr;
        logic          chk_rd;
        logic [RW-1:0] rd;
    } exp_t;

    exp_t sb_q[$];
    int   n_edge = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: capture described as "what happened since arm" in plain integers.
    int            m_state = 0, m_wr = 0, m_tp = 0, m_wrapped = 0, m_ts = 0, m_post = 0, m_first = 0;
    logic [DW-1:0] m_prev1 = '0, m_prev2 = '0;
    logic [RW-1:0] m_mem [DL];
    bit            m_known [DL];

    always @(posedge clk_cap) n_edge++;

    always @(negedge clk_cap) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].due <= n_edge) begin
            e = sb_q.pop_front();
            checks++;
            if ({state, wr_ptr, trig_ptr, wrapped} !== {e.st, e.wp, e.tp, e.wr}) begin
                errors++;
                $display("FAIL status edge=%0d got st=%0d wp=%0d tp=%0d wrapped=%0d want st=%0d wp=%0d tp=%0d wrapped=%0d",
                         e.due, state, wr_ptr, trig_ptr, wrapped, e.st, e.wp, e.tp, e.wr);
            end
            if (e.chk_rd) begin
                checks++;
                if (rd_data !== e.rd) begin
                    errors++;
                    $display("FAIL rd_data edge=%0d got %h want %h", e.due, rd_data, e.rd);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // One clock: drive inputs, advance the model, queue what the DUT must show after the edge.
    task automatic step(input logic [DW-1:0] ev, input logic a, input logic t, input logic r, input int ra);
        exp_t e;
        int   code;
        int   wr_before;
        events  = ev;
        arm     = a;
        trigger = t;
        reset   = r;
        rd_addr = ra[DB-1:0];
        e.due   = n_edge + 1;
        if (r) begin
            e.chk_rd = 1'b1;
            e.rd     = '0;
        end else begin
            e.chk_rd = m_known[ra];
            e.rd     = m_mem[ra];
        end
        if (r) begin
            m_state = 0; m_wr = 0; m_tp = 0; m_wrapped = 0;
        end else if (m_state == 0 || m_state == 3) begin
            if (a) begin
                m_state = 1; m_ts = 0; m_wr = 0; m_wrapped = 0; m_first = 1;
            end
        end else begin
            code = 0;
            wr_before = m_wr;
            if (m_state == 1 && t) code = 1;
            else if (m_ts == (1 << TB) - 1) code = 2;
            else if (m_first != 0 || ((m_prev1 ^ m_prev2) & ~mask_v) != '0) code = 3;
            m_first = 0;
            if (code != 0) begin
                m_mem[m_wr]   = {code[1:0], m_ts[TB-1:0], m_prev1};
                m_known[m_wr] = 1'b1;
                if (m_wr == DL - 1) m_wrapped = 1;
                m_wr = (m_wr + 1) % DL;
            end
            m_ts = (m_ts + 1) % (1 << TB);
            if (code == 1) begin
                m_tp    = wr_before;
                m_post  = int'(cfg_post_len);
                m_state = (m_post == 0) ? 3 : 2;
            end else if (m_state == 2 && code != 0) begin
                m_post--;
                if (m_post == 0) m_state = 3;
            end
        end
        m_prev2 = m_prev1;
        m_prev1 = ev;
        e.st = m_state[1:0];
        e.wp = m_wr[DB-1:0];
        e.tp = m_tp[DB-1:0];
        e.wr = m_wrapped[0];
        sb_q.push_back(e);
        @(negedge clk_cap);
    endtask

    task automatic readback_all(input logic [DW-1:0] ev);
        for (int a = 0; a < DL; a++) step(ev, 1'b0, 1'b0, 1'b0, a);
    endtask

    initial begin
        logic [DW-1:0] ev;
        for (int i = 0; i < DL; i++) m_known[i] = 1'b0;

        // Reset state
        step('0, 1'b0, 1'b0, 1'b1, 0);
        step('0, 1'b0, 1'b0, 1'b1, 0);
        chk("reset_state", int'(state), 0);
        chk("reset_wr_ptr", int'(wr_ptr), 0);
        chk("reset_rd_data", int'(rd_data), 0);

        // Constant events: only the baseline entry
        step('0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 14; k++) step('0, 1'b0, 1'b0, 1'b0, 0);
        chk("t1_wr_ptr", int'(wr_ptr), 1);
        step('0, 1'b0, 1'b0, 1'b0, 0);
        chk("t1_entry", int'(rd_data), 'h3000);

        // Constant events: rollover markers at ts=0xF
        step('0, 1'b0, 1'b0, 1'b1, 0);
        step(8'h5A, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 0; k < 40; k++) step(8'h5A, 1'b0, 1'b0, 1'b0, 0);
        chk("t2_wr_ptr", int'(wr_ptr), 3);
        step(8'h5A, 1'b0, 1'b0, 1'b0, 1);
        chk("t2_roll_entry", int'(rd_data), 'h2F5A);

        // Change, trigger, 3 post entries
        step('0, 1'b0, 1'b0, 1'b1, 0);
        cfg_post_len = 4'd3;
        step('0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 16; k++) begin
            ev = (k < 5) ? 8'h00 : (k <= 8) ? 8'h03 : ((k % 2) == 0 ? 8'h03 : 8'h00);
            step(ev, 1'b0, k == 8, 1'b0, k % DL);
        end
        chk("t3_trig_ptr", int'(trig_ptr), 2);
        chk("t3_wr_ptr", int'(wr_ptr), 6);
        chk("t3_state", int'(state), 3);
        readback_all(8'h00);

        // Wrap plus maximum post length
        step('0, 1'b0, 1'b0, 1'b1, 0);
        cfg_post_len = 4'd15;
        step('0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 71; k++) step(((k % 2) != 0) ? 8'h03 : 8'h00, 1'b0, k == 41, 1'b0, k % DL);
        chk("t4_trig_ptr", int'(trig_ptr), 8);
        chk("t4_wr_ptr", int'(wr_ptr), 8);
        chk("t4_wrapped", int'(wrapped), 1);
        chk("t4_state", int'(state), 3);

        // Reset in POST: state cleared, pending write suppressed
        step('0, 1'b0, 1'b0, 1'b1, 0);
        cfg_post_len = 4'd10;
        step('0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 5; k++) step(((k % 2) != 0) ? 8'h03 : 8'h00, 1'b0, k == 3, 1'b0, 0);
        chk("t5_pre_state", int'(state), 2);
        step(8'h03, 1'b0, 1'b0, 1'b1, 0);
        chk("t5_state", int'(state), 0);
        chk("t5_wr_ptr", int'(wr_ptr), 0);
        chk("t5_wrapped", int'(wrapped), 0);
        readback_all(8'h03);

`ifdef SUMP3_RLE_MASK_EN
        // Masked bit0 toggles are ignored, bit1 toggles are recorded
        mask_v = 8'h01;
        step('0, 1'b0, 1'b0, 1'b1, 0);
        step('0, 1'b1, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 6; k++) step(((k % 2) != 0) ? 8'h01 : 8'h00, 1'b0, 1'b0, 1'b0, 0);
        chk("t6_masked_wr_ptr", int'(wr_ptr), 1);
        for (int k = 1; k <= 3; k++) step(8'h02, 1'b0, 1'b0, 1'b0, 0);
        chk("t6_unmasked_wr_ptr", int'(wr_ptr), 2);
`endif

        // Random traffic against the model
        ev = '0;
        for (int n = 0; n < 900; n++) begin
            logic a, t, r;
            if ($urandom_range(0, 2) == 0) ev = DW'($urandom);
            a = ($urandom_range(0, 24) == 0);
            t = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 149) == 0);
            if (a) cfg_post_len = DB'($urandom_range(0, DL - 1));
            step(ev, a, t, r, $urandom_range(0, DL - 1));
        end

        repeat (2) @(negedge clk_cap);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
